// File: rtl/bus_sched_pkg.sv
// Shared types and helpers for the round-robin packet bus scheduler.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package bus_sched_pkg;

    localparam int MAX_DRVS = 16;
    localparam int PKT_MAX  = 128;

    localparam logic [7:0] BROADCAST_DEF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        SEND = 2'd2
    } state_t;

    // Destination byte sits in the top 8 bits of a packet of width sz.
    function automatic logic [7:0] dest_of(input logic [PKT_MAX-1:0] pkt, input int sz);
        return pkt[sz-1 -: 8];
    endfunction

    // Every device on the bus except the source.
    function automatic logic [MAX_DRVS-1:0] bcast_mask(input logic [3:0] src, input int drvs);
        logic [MAX_DRVS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_DRVS; i++) begin
            if (i < drvs && i != int'(src)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first requester after ptr, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; any=0 when no request is set.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [3:0]   ptr,
    output logic [3:0]   gnt_idx,
    output logic         any
);

    // Pick the requester with the smallest rotated distance from ptr+1.
    always_comb begin
        int best;
        int d;
        gnt_idx = '0;
        best    = N;
        d       = 0;
        for (int i = 0; i < N; i++) begin
            d = (i + 2 * N - int'(ptr) - 1) % N;
            if (req[i] && d < best) begin
                best    = d;
                gnt_idx = 4'(i);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin bus scheduler: pops one packet from a granted device and pushes it to its destination(s).
// Latency: pndng seen in IDLE at cycle 0, pop at cycle 1, push at cycle 2 (one packet per 3 cycles best case).
// Backpressure: a full destination stalls in SEND with data held; invalid destinations are dropped and counted.
module bus_rr_scheduler
    import bus_sched_pkg::*;
#(
    parameter int         DRVS      = 4,
    parameter int         PCKG_SZ   = 16,
    parameter logic [7:0] BROADCAST = BROADCAST_DEF,
    parameter int         CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DRVS-1:0]           pndng,
    input  logic [DRVS*PCKG_SZ-1:0]   D_pop,
    input  logic [DRVS-1:0]           dst_full,
    output logic [DRVS-1:0]           pop,
    output logic [DRVS-1:0]           push,
    output logic [PCKG_SZ-1:0]        D_push,
    output logic [3:0]                grant_id,
    output logic                      busy,
    output logic [CNT_W-1:0]          drop_cnt
);

    state_t               state, state_nxt;
    logic [3:0]           rr_ptr;
    logic [PCKG_SZ-1:0]   data_q;
    logic [PCKG_SZ-1:0]   d_last;
    logic [PKT_MAX-1:0]   data_ext;
    logic [7:0]           dest;
    logic [DRVS-1:0]      src_oh;
    logic [DRVS-1:0]      tgt_mask;
    logic                 src_pndng;
    logic                 dest_ok;
    logic                 blocked;
    logic [3:0]           pick_idx;
    logic                 pick_any;

    rr_pick #(.N(DRVS)) u_pick (
        .req     (pndng),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign src_oh    = DRVS'(1) << grant_id;
    assign src_pndng = |(pndng & src_oh);
    assign busy      = (state != IDLE);
    assign D_push    = (|push) ? data_q : d_last;

    // Decode the latched packet's destination into a target mask.
    always_comb begin
        data_ext                = '0;
        data_ext[PCKG_SZ-1:0]   = data_q;
        dest                    = dest_of(data_ext, PCKG_SZ);
        tgt_mask                = '0;
        dest_ok                 = 1'b0;
        if (dest == BROADCAST) begin
            tgt_mask = DRVS'(bcast_mask(grant_id, DRVS));
            dest_ok  = 1'b1;
        end else if (int'(dest) < DRVS) begin
            tgt_mask = DRVS'(1) << dest;
            dest_ok  = 1'b1;
        end
        blocked = |(tgt_mask & dst_full);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and pop/push strobes; the two strobes come from different states.
    always_comb begin
        state_nxt = state;
        pop       = '0;
        push      = '0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = POP;
                end
            end
            POP: begin
                if (src_pndng) begin
                    pop       = src_oh;
                    state_nxt = SEND;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SEND: begin
                if (!dest_ok) begin
                    state_nxt = IDLE;
                end else if (!blocked) begin
                    push      = tgt_mask;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant capture, packet latch and round-robin pointer advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_id <= '0;
            rr_ptr   <= 4'(DRVS - 1);
            data_q   <= '0;
            d_last   <= '0;
        end else begin
            if (state == IDLE && pick_any) begin
                grant_id <= pick_idx;
            end
            if (|pop) begin
                data_q <= D_pop[int'(grant_id) * PCKG_SZ +: PCKG_SZ];
            end
            if (|push) begin
                d_last <= data_q;
            end
            if (state == SEND && (!dest_ok || !blocked)) begin
                rr_ptr <= grant_id;
            end
        end
    end

    // Saturating count of packets whose destination matches no device.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (state == SEND && !dest_ok && drop_cnt != '1) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Self-checking bench for bus_rr_scheduler: randomized traffic against a transaction-level model plus directed scenarios.
// Latency: n/a.
// Backpressure: dst_full driven randomly and in directed stall scenarios.
module tb_bus_rr_scheduler;

    localparam int DRVS = 4;
    localparam int PSZ  = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [DRVS-1:0]    pndng = '0;
    logic [DRVS*PSZ-1:0] D_pop = '0;
    logic [DRVS-1:0]    dst_full = '0;
    logic [DRVS-1:0]    pop;
    logic [DRVS-1:0]    push;
    logic [PSZ-1:0]     D_push;
    logic [3:0]         grant_id;
    logic               busy;
    logic [15:0]        drop_cnt;

    always #5 clk = ~clk;

    bus_rr_scheduler #(.DRVS(DRVS), .PCKG_SZ(PSZ), .BROADCAST(8'hFF), .CNT_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .dst_full (dst_full),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .grant_id (grant_id),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: which phase of a transfer we are in, who owns the bus, and what it sent.
    int          m_st;      // 0 waiting, 1 popping, 2 delivering
    int          m_gid;
    int          m_ptr;
    int          m_drop;
    logic [15:0] m_data;
    logic [15:0] m_dlast;

    logic [3:0]  o_pop, o_push, o_gid;
    logic [15:0] o_dpush, o_drop;
    logic        o_busy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_gid = 0; m_ptr = DRVS - 1; m_drop = 0; m_data = '0; m_dlast = '0;
    endtask

    // One clock cycle: drive inputs, compare all outputs with the model, advance the model.
    task automatic step(input logic [3:0] pn, input logic [63:0] dp, input logic [3:0] df, input logic rs);
        int dest, mask, epop, epush, nst, ngid, nptr, ndrop;
        logic valid;
        logic [15:0] ndata, ndlast, edp;
        @(negedge clk);
        pndng = pn; D_pop = dp; dst_full = df; reset = rs;
        #1;
        if (rs) model_reset();
        dest = int'(m_data[15:8]);
        valid = 1'b0; mask = 0;
        if (dest == 255) begin
            mask = ((1 << DRVS) - 1) & ~(1 << m_gid); valid = 1'b1;
        end else if (dest < DRVS) begin
            mask = 1 << dest; valid = 1'b1;
        end
        epop = (m_st == 1 && pn[m_gid]) ? (1 << m_gid) : 0;
        epush = (m_st == 2 && valid && (mask & int'(df)) == 0) ? mask : 0;
        edp = (epush != 0) ? m_data : m_dlast;
        o_pop = pop; o_push = push; o_dpush = D_push; o_gid = grant_id; o_busy = busy; o_drop = drop_cnt;
        chk("pop", 32'(o_pop), epop);
        chk("push", 32'(o_push), epush);
        chk("D_push", 32'(o_dpush), 32'(edp));
        chk("grant_id", 32'(o_gid), m_gid);
        chk("busy", 32'(o_busy), (m_st != 0) ? 1 : 0);
        chk("drop_cnt", 32'(o_drop), m_drop);
        nst = m_st; ngid = m_gid; nptr = m_ptr; ndrop = m_drop; ndata = m_data; ndlast = m_dlast;
        case (m_st)
            0: begin
                for (int k = 1; k <= DRVS; k++) begin
                    if (nst == 0 && pn[(m_ptr + k) % DRVS]) begin
                        ngid = (m_ptr + k) % DRVS; nst = 1;
                    end
                end
            end
            1: begin
                if (pn[m_gid]) begin
                    ndata = dp[m_gid * PSZ +: PSZ]; nst = 2;
                end else begin
                    nst = 0;
                end
            end
            default: begin
                if (!valid) begin
                    ndrop = (m_drop < 65535) ? m_drop + 1 : m_drop; nptr = m_gid; nst = 0;
                end else if (epush != 0) begin
                    ndlast = m_data; nptr = m_gid; nst = 0;
                end
            end
        endcase
        @(posedge clk);
        if (!rs) begin
            m_st = nst; m_gid = ngid; m_ptr = nptr; m_drop = ndrop; m_data = ndata; m_dlast = ndlast;
        end
    endtask

    function automatic logic [63:0] dp1(input int dev, input logic [15:0] v);
        logic [63:0] r;
        r = '0;
        r[dev * PSZ +: PSZ] = v;
        return r;
    endfunction

    function automatic logic [63:0] rand_dpop();
        logic [63:0] r;
        int sel;
        logic [7:0] d;
        r = '0;
        for (int i = 0; i < DRVS; i++) begin
            sel = $urandom_range(7);
            if (sel <= 4) d = 8'($urandom_range(DRVS - 1));
            else if (sel == 5) d = 8'hFF;
            else d = 8'($urandom_range(255));
            r[i * PSZ +: PSZ] = {d, 8'($urandom_range(255))};
        end
        return r;
    endfunction

    task automatic drain();
        repeat (3) step(4'b0000, '0, 4'b0000, 1'b0);
    endtask

    task automatic random_run(input int n, input bit with_reset);
        logic [3:0] df;
        for (int i = 0; i < n; i++) begin
            df = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'b0000;
            step(4'($urandom_range(15)), rand_dpop(), df, with_reset && ($urandom_range(199) == 0));
        end
    endtask

    initial begin
        int gq[$];
        int pcyc[$];
        int d0;

        model_reset();
        step(4'b0000, '0, 4'b0000, 1'b1);
        random_run(60, 1'b0);

        // Reset in the middle of traffic: everything back to zero immediately.
        step(4'b1111, rand_dpop(), 4'b0000, 1'b1);
        chk("rst_pop", 32'(o_pop), 0);
        chk("rst_push", 32'(o_push), 0);
        chk("rst_dpush", 32'(o_dpush), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_gid", 32'(o_gid), 0);
        chk("rst_drop", 32'(o_drop), 0);

        // Fairness: all devices pending, grants rotate starting at device 0.
        for (int c = 0; c < 15; c++) begin
            step(4'b1111, {16'h00A3, 16'h03A2, 16'h02A1, 16'h01A0}, 4'b0000, 1'b0);
            if (o_pop != 0) gq.push_back(int'(o_gid));
            if (o_push != 0) pcyc.push_back(c);
        end
        chk("fair_ngrants", gq.size(), 5);
        chk("fair_npush", pcyc.size(), 5);
        for (int i = 0; i < 5 && i < gq.size(); i++) chk("fair_grant", gq[i], i % DRVS);
        for (int i = 0; i < 5 && i < pcyc.size(); i++) chk("fair_push_cycle", pcyc[i], 2 + 3 * i);

        // Unicast from device 2 to device 1.
        drain();
        step(4'b0100, dp1(2, 16'h01AB), 4'b0000, 1'b0);
        step(4'b0100, dp1(2, 16'h01AB), 4'b0000, 1'b0);
        chk("uni_pop", 32'(o_pop), 32'h4);
        step(4'b0000, '0, 4'b0000, 1'b0);
        chk("uni_push", 32'(o_push), 32'h2);
        chk("uni_dpush", 32'(o_dpush), 32'h01AB);
        step(4'b0000, '0, 4'b0000, 1'b0);
        chk("uni_idle", 32'(o_busy), 0);
        chk("uni_dhold", 32'(o_dpush), 32'h01AB);

        // Broadcast from device 0.
        drain();
        d0 = int'(o_drop);
        step(4'b0001, dp1(0, 16'hFF55), 4'b0000, 1'b0);
        step(4'b0001, dp1(0, 16'hFF55), 4'b0000, 1'b0);
        chk("bc_pop", 32'(o_pop), 32'h1);
        step(4'b0000, '0, 4'b0000, 1'b0);
        chk("bc_push", 32'(o_push), 32'hE);
        chk("bc_dpush", 32'(o_dpush), 32'hFF55);
        chk("bc_drop", 32'(o_drop), d0);

        // Invalid destination from device 1: popped, never pushed, counted.
        drain();
        step(4'b0010, dp1(1, 16'h0700), 4'b0000, 1'b0);
        step(4'b0010, dp1(1, 16'h0700), 4'b0000, 1'b0);
        chk("inv_pop", 32'(o_pop), 32'h2);
        step(4'b0000, '0, 4'b0000, 1'b0);
        chk("inv_push", 32'(o_push), 0);
        step(4'b0000, '0, 4'b0000, 1'b0);
        chk("inv_drop", 32'(o_drop), 1);
        chk("inv_idle", 32'(o_busy), 0);

        // Destination full: stall, then deliver once released.
        drain();
        step(4'b0001, dp1(0, 16'h0312), 4'b1000, 1'b0);
        step(4'b0001, dp1(0, 16'h0312), 4'b1000, 1'b0);
        step(4'b0000, '0, 4'b1000, 1'b0);
        chk("bp_stall1", 32'(o_push), 0);
        chk("bp_busy", 32'(o_busy), 1);
        step(4'b0000, '0, 4'b1000, 1'b0);
        chk("bp_stall2", 32'(o_push), 0);
        step(4'b0000, '0, 4'b0000, 1'b0);
        chk("bp_push", 32'(o_push), 32'h8);
        chk("bp_dpush", 32'(o_dpush), 32'h0312);

        // Same stall, but reset kills the packet: nothing is ever pushed.
        drain();
        step(4'b0001, dp1(0, 16'h0312), 4'b1000, 1'b0);
        step(4'b0001, dp1(0, 16'h0312), 4'b1000, 1'b0);
        step(4'b0000, '0, 4'b1000, 1'b0);
        step(4'b0000, '0, 4'b1000, 1'b1);
        chk("rs_push", 32'(o_push), 0);
        chk("rs_busy", 32'(o_busy), 0);
        for (int i = 0; i < 4; i++) begin
            step(4'b0000, '0, 4'b0000, 1'b0);
            chk("rs_nopush", 32'(o_push), 0);
        end

        random_run(3000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_rr_scheduler.md
Name: bus_rr_scheduler

Overview:
- Round-robin scheduler that shares one packet bus between DRVS device FIFOs.
- Polls each device's pending flag and pops one packet from the granted device.
- Decodes the destination field of the packet and pushes it into the destination FIFO, or into every other device on broadcast.
- Sits between the per-device FIFO interface (pndng/pop/D_pop, push/D_push) and the device array, in place of a fixed-priority bus controller.

Parameters:
- DRVS, 4: number of devices on the bus (2..16).
- PCKG_SZ, 16: packet width in bits. Destination field is bits [PCKG_SZ-1:PCKG_SZ-8].
- BROADCAST, 8'hFF: destination value meaning "all devices except the source".
- CNT_W, 16: width of the dropped-packet counter.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- pndng  in  DRVS  bit i high = device i FIFO holds at least one packet.
- D_pop  in  DRVS*PCKG_SZ  head-of-FIFO data of device i in slice [i*PCKG_SZ +: PCKG_SZ]; show-ahead.
- dst_full  in  DRVS  bit i high = device i receive FIFO cannot accept a push.
- pop  out  DRVS  one-hot pop strobe to the granted source FIFO.
- push  out  DRVS  push strobe mask to the destination FIFO(s).
- D_push  out  PCKG_SZ  shared bus data, valid while any push bit is high.
- grant_id  out  4  index of the current/last granted source.
- busy  out  1  high in every state except IDLE.
- drop_cnt  out  CNT_W  saturating count of packets with an invalid destination.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, rr_ptr=DRVS-1 (device 0 wins first), grant_id=0.
  - pop=0, push=0, D_push=0, busy=0, drop_cnt=0.
  - A packet in flight is lost; no partial push occurs.
- FSM states IDLE, POP, SEND. pop and push are decoded from the state and are never high in the same cycle.
- IDLE:
  - If pndng!=0, select the first set bit scanning rr_ptr+1, rr_ptr+2, ... with wrap modulo DRVS.
  - Register it in grant_id and go to POP. Otherwise stay in IDLE.
- POP:
  - If pndng[grant_id]=1: assert pop[grant_id] for exactly this cycle, latch the D_pop slice into data_q on the same edge, and go to SEND.
  - If pndng[grant_id]=0 (protocol violation): no pop; return to IDLE.
- SEND: dest = data_q[PCKG_SZ-1 -: 8].
  - dest==BROADCAST: target mask = all ones except bit grant_id.
  - dest<DRVS: target mask = one-hot(dest). Self-addressing is permitted.
  - Otherwise: drop the packet, drop_cnt += 1 (saturates at all ones), rr_ptr=grant_id, go to IDLE. No push.
  - If any bit of (mask & dst_full) is set: stall in SEND with push=0 and data_q held.
  - Else: push=mask and D_push=data_q for one cycle, rr_ptr=grant_id, go to IDLE.
- D_push holds its last value after a push (it is not zeroed).
- Latency:
  - pndng sampled in IDLE at cycle 0 → pop at cycle 1 → push at cycle 2.
  - Best-case throughput is one packet per 3 cycles.
- Fairness:
  - With every pndng held high, grants rotate 0,1,...,DRVS-1,0.
  - No device waits more than DRVS-1 other grants.
- pndng changes while in SEND are ignored until the next IDLE.
- dst_full changing during a SEND stall is re-evaluated every cycle.

Decomposition:
- Package bus_sched_pkg holds:
  - state enum {IDLE, POP, SEND};
  - BROADCAST default constant;
  - function dest_of(packet) returning the 8-bit destination field;
  - function bcast_mask(src, DRVS).
- One sub-module, rr_pick: combinational rotating priority encoder.
  - Inputs: req[DRVS], ptr.
  - Outputs: gnt_idx, any.
  - Instantiated once in IDLE arbitration.

Test Plan:
- Reset check: drive reset=1 mid-stream → all outputs 0, busy=0. After release, the first grant with pndng=4'b1111 goes to device 0.
- Unicast: pndng=4'b0100, D_pop[2]=16'h01AB.
  - cycle 1: pop=4'b0100.
  - cycle 2: push=4'b0010, D_push=16'h01AB.
  - cycle 3: busy=0.
- Broadcast: device 0 sends 16'hFF55 → push=4'b1110, D_push=16'hFF55, drop_cnt unchanged.
- Invalid destination: device 1 sends 16'h0700 → pop[1] pulses, push stays 0, drop_cnt=1, FSM back in IDLE.
- Fairness: pndng=4'b1111 held for 15 cycles → grant_id sequence 0,1,2,3,0, one push every 3 cycles.
- Backpressure and reset during stall:
  - dst_full=4'b1000; device 0 sends 16'h0312 → stays in SEND, push=0.
  - Release dst_full → push=4'b1000 the next cycle.
  - Repeat with reset asserted during the stall → IDLE, and no push ever appears.
